// File: rtl/clken_gen_pkg.sv
// Shared types and helpers for the clock-enable generator.
package clken_pkg;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    LOCKED = 2'd1,
    APPLY  = 2'd2
  } state_t;

  localparam int unsigned DEF_DIV   = 1;
  localparam int unsigned DEF_PHASE = 0;

  // A zero divide ratio behaves as divide-by-one.
  function automatic logic [31:0] eff_div(input logic [31:0] div);
    return (div == 32'd0) ? 32'd1 : div;
  endfunction

  // The strobe offset must fall inside the period.
  function automatic logic [31:0] clamp_phase(input logic [31:0] phase, input logic [31:0] div);
    logic [31:0] d;
    d = eff_div(div);
    return (phase > d - 32'd1) ? d - 32'd1 : phase;
  endfunction

endpackage

// File: rtl/clken_gen_chan.sv
// One output channel: divide/phase registers, wrapping counter and
// next-cycle raw strobe/level so the top can register them.
module clken_chan
  import clken_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic             clr,
  input  logic [CNT_W-1:0] div_in,
  input  logic [CNT_W-1:0] phase_in,
  output logic             en_nxt,
  output logic             lvl_nxt
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] div, phase, cnt;
  logic [CNT_W-1:0] div_n, phase_n, cnt_n;

  always_comb begin
    div_n   = div;
    phase_n = phase;
    if (wr) begin
      div_n   = CNT_W'(eff_div(32'(div_in)));
      phase_n = CNT_W'(clamp_phase(32'(phase_in), 32'(div_in)));
    end
    // clr is always asserted alongside wr, so the old div is safe for the wrap.
    if (clr || (cnt >= div - ONE)) cnt_n = '0;
    else                           cnt_n = cnt + ONE;
    en_nxt  = (cnt_n == phase_n);
    lvl_nxt = (div_n == ONE) || (cnt_n < (div_n >> 1));
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      div   <= CNT_W'(DEF_DIV);
      phase <= CNT_W'(DEF_PHASE);
      cnt   <= '0;
    end else begin
      div   <= div_n;
      phase <= phase_n;
      cnt   <= cnt_n;
    end
  end

endmodule

// File: rtl/clken_gen.sv
// Multi-channel clock-enable generator: settle/lock FSM, config handshake,
// per-channel dividers and registered, lock-gated outputs.
module clken_gen
  import clken_pkg::*;
#(
  parameter  int NUM_CH      = 3,
  parameter  int CNT_W       = 16,
  parameter  int LOCK_CYCLES = 16,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int SET_W       = $clog2(LOCK_CYCLES + 1)
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_phase,
  output logic [NUM_CH-1:0] out_en,
  output logic [NUM_CH-1:0] out_lvl,
  output logic              locked
);

  state_t           state, state_nxt;
  logic [SET_W-1:0] settle_cnt, settle_nxt;
  logic             hs, clr, locked_nxt;
  logic [NUM_CH-1:0] wr, en_nxt, lvl_nxt;

  assign hs  = cfg_valid && (state == LOCKED);
  // Counters are held at zero on the accepting edge and through APPLY,
  // so every channel restarts on the first SETTLE cycle.
  assign clr = hs || (state == APPLY);

  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    case (state)
      SETTLE: begin
        if (settle_cnt == SET_W'(LOCK_CYCLES - 1)) begin
          state_nxt  = LOCKED;
          settle_nxt = '0;
        end else begin
          settle_nxt = settle_cnt + SET_W'(1);
        end
      end
      LOCKED: if (cfg_valid) state_nxt = APPLY;
      APPLY: begin
        state_nxt  = SETTLE;
        settle_nxt = '0;
      end
      default: begin
        state_nxt  = SETTLE;
        settle_nxt = '0;
      end
    endcase
  end

  assign locked_nxt = (state_nxt == LOCKED);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign wr[g] = hs && (cfg_ch == CH_W'(g));
    clken_chan #(.CNT_W(CNT_W)) u_chan (
      .refclk  (refclk),
      .rst_n   (rst_n),
      .wr      (wr[g]),
      .clr     (clr),
      .div_in  (cfg_div),
      .phase_in(cfg_phase),
      .en_nxt  (en_nxt[g]),
      .lvl_nxt (lvl_nxt[g])
    );
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SETTLE;
      settle_cnt <= '0;
      locked     <= 1'b0;
      cfg_ready  <= 1'b0;
      out_en     <= '0;
      out_lvl    <= '0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      locked     <= locked_nxt;
      cfg_ready  <= locked_nxt;
      out_en     <= locked_nxt ? en_nxt  : '0;
      out_lvl    <= locked_nxt ? lvl_nxt : '0;
    end
  end

endmodule
